// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Key codes, 4x4 keymap and debounce state type for keypad_entry.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam logic [3:0] KEY_A   = 4'hA;
    localparam logic [3:0] KEY_B   = 4'hB;
    localparam logic [3:0] KEY_C   = 4'hC;
    localparam logic [3:0] KEY_D   = 4'hD;
    localparam logic [3:0] KEY_CLR = 4'hE;
    localparam logic [3:0] KEY_ENT = 4'hF;

    typedef enum logic [0:0] {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } deb_state_t;

    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = KEY_A;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = KEY_B;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = KEY_C;
            4'd12:   code = KEY_CLR;
            4'd13:   code = 4'd0;
            4'd14:   code = KEY_ENT;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan
// Description : Column scanner, row synchronizer, snapshot builder and
//               press/release debounce FSM producing one key_event per press.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_event,
    output logic [3:0] key_code
);

    localparam int              DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      c_deb      = 4'(DEBOUNCE);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col;
    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [11:0]      r_snap_part;

    deb_state_t r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt, w_cnt_run;
    logic [3:0] r_prev_code, w_prev_nxt;
    logic       r_event, w_event_nxt;
    logic [3:0] r_code, w_code_nxt;

    logic        w_sample;
    logic        w_snap_done;
    logic [15:0] w_snap;
    logic        w_any;
    logic        w_multi;
    logic [3:0]  w_code;

    assign key_col     = ~(4'b0001 << r_col);
    assign w_sample    = (r_div == c_div_last);
    assign w_snap_done = w_sample && (r_col == 2'd3);
    // Snapshot bit index is col*4+row; set bit means key down.
    assign w_snap      = {~r_row_sync, r_snap_part};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div       <= '0;
            r_col       <= 2'd0;
            r_row_meta  <= 4'hF;
            r_row_sync  <= 4'hF;
            r_snap_part <= '0;
        end else begin
            r_row_meta <= key_row;
            r_row_sync <= r_row_meta;
            if (w_sample) begin
                r_div <= '0;
                r_col <= r_col + 2'd1;
                if (r_col != 2'd3) begin
                    r_snap_part[{r_col, 2'b00} +: 4] <= ~r_row_sync;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_any   = 1'b0;
        w_multi = 1'b0;
        w_code  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_snap[i]) begin
                if (w_any) w_multi = 1'b1;
                w_any  = 1'b1;
                w_code = keymap(2'(i % 4), 2'(i / 4));
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= RELEASED;
            r_cnt       <= 4'd0;
            r_prev_code <= 4'd0;
            r_event     <= 1'b0;
            r_code      <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_prev_code <= w_prev_nxt;
            r_event     <= w_event_nxt;
            r_code      <= w_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_prev_nxt  = r_prev_code;
        w_event_nxt = 1'b0;
        w_code_nxt  = r_code;
        w_cnt_run   = 4'd1;
        if (w_snap_done) begin
            case (r_state)
                RELEASED: begin
                    if (w_any && !w_multi) begin
                        w_prev_nxt = w_code;
                        // A run only continues if the previous snapshot held the same single key.
                        w_cnt_run  = (r_cnt != 4'd0 && w_code == r_prev_code) ? r_cnt + 4'd1 : 4'd1;
                        if (w_cnt_run == c_deb) begin
                            w_event_nxt = 1'b1;
                            w_code_nxt  = w_code;
                            w_state_nxt = PRESSED;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = w_cnt_run;
                        end
                    end else begin
                        w_cnt_nxt = 4'd0;
                    end
                end
                default: begin
                    if (!w_any) begin
                        if (r_cnt + 4'd1 == c_deb) begin
                            w_state_nxt = RELEASED;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt = r_cnt + 4'd1;
                        end
                    end else begin
                        w_cnt_nxt = 4'd0;
                    end
                end
            endcase
        end
    end

    assign key_event = r_event;
    assign key_code  = r_code;

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry
// Description : Accumulates up to three decimal key digits into an 8-bit value
//               and hands it off with a one-cycle valid pulse on confirm.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [7:0] value,
    output logic [1:0] digit_cnt,
    output logic       entry_valid,
    output logic [7:0] entry_value,
    output logic       key_err
);

    logic       w_event;
    logic [3:0] w_code;
    logic [9:0] w_new;

    logic [7:0] r_acc;
    logic [1:0] r_cnt;
    logic       r_valid;
    logic [7:0] r_entry;
    logic       r_err;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) u_scan (
        .clk       (clk),
        .rstn      (rstn),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_event (w_event),
        .key_code  (w_code)
    );

    // 10 bits suffice: with fewer than three digits the accumulator is at most 99.
    assign w_new = 10'(r_acc) * 10'd10 + 10'(w_code);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc   <= 8'd0;
            r_cnt   <= 2'd0;
            r_valid <= 1'b0;
            r_entry <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_event) begin
                if (w_code <= 4'd9) begin
                    if (r_cnt == 2'd3 || w_new > 10'd255) begin
                        r_err <= 1'b1;
                    end else begin
                        r_acc <= w_new[7:0];
                        r_cnt <= r_cnt + 2'd1;
                    end
                end else if (w_code == KEY_CLR) begin
                    r_acc <= 8'd0;
                    r_cnt <= 2'd0;
                end else if (w_code == KEY_ENT && r_cnt != 2'd0) begin
                    r_entry <= r_acc;
                    r_valid <= 1'b1;
                    r_acc   <= 8'd0;
                    r_cnt   <= 2'd0;
                end
            end
        end
    end

    assign value       = r_acc;
    assign digit_cnt   = r_cnt;
    assign entry_valid = r_valid;
    assign entry_value = r_entry;
    assign key_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry
// Description : Scoreboard bench for keypad_entry with a keypad matrix model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_entry;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [7:0] value;
    logic [1:0] digit_cnt;
    logic       entry_valid;
    logic [7:0] entry_value;
    logic       key_err;

    logic [15:0] keys_down;   // index row*4+col

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [7:0] val;
        logic [1:0] cnt;
        logic [7:0] ev;
    } exp_t;

    exp_t q[$];
    int   m_acc, m_cnt, m_ev;
    int   kmap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_entry #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_row     (key_row),
        .key_col     (key_col),
        .value       (value),
        .digit_cnt   (digit_cnt),
        .entry_valid (entry_valid),
        .entry_value (entry_value),
        .key_err     (key_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pos_of(input int code);
        for (int i = 0; i < 16; i++) if (kmap[i] == code) return i;
        return 0;
    endfunction

    task automatic push_exp(input logic v, input logic e);
        exp_t x;
        x.valid = v;
        x.err   = e;
        x.val   = 8'(m_acc);
        x.cnt   = 2'(m_cnt);
        x.ev    = 8'(m_ev);
        q.push_back(x);
    endtask

    // Reference: decimal entry rules applied to one accepted key.
    task automatic model_key(input int code);
        int nv;
        if (code <= 9) begin
            nv = m_acc * 10 + code;
            if (m_cnt == 3 || nv > 255) push_exp(1'b0, 1'b1);
            else begin
                m_acc = nv;
                m_cnt = m_cnt + 1;
                push_exp(1'b0, 1'b0);
            end
        end else if (code == 14) begin
            if (m_acc != 0 || m_cnt != 0) begin
                m_acc = 0;
                m_cnt = 0;
                push_exp(1'b0, 1'b0);
            end
        end else if (code == 15) begin
            if (m_cnt > 0) begin
                m_ev  = m_acc;
                m_acc = 0;
                m_cnt = 0;
                push_exp(1'b1, 1'b0);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int code, input int hold, input int rel);
        int p;
        p = pos_of(code);
        wait_cyc($urandom_range(0, SCAN - 1));
        model_key(code);
        keys_down[p] = 1'b1;
        wait_cyc(hold * SCAN);
        keys_down[p] = 1'b0;
        wait_cyc(rel * SCAN);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_value"}, 32'(value), 32'(m_acc));
        check({tag, "_cnt"}, 32'(digit_cnt), 32'(m_cnt));
        check({tag, "_entry_value"}, 32'(entry_value), 32'(m_ev));
        check({tag, "_pending"}, 32'(q.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_key_col"}, 32'(key_col), 32'h0000000E);
        check({tag, "_value"}, 32'(value), 32'd0);
        check({tag, "_cnt"}, 32'(digit_cnt), 32'd0);
        check({tag, "_valid"}, 32'(entry_valid), 32'd0);
        check({tag, "_entry_value"}, 32'(entry_value), 32'd0);
        check({tag, "_err"}, 32'(key_err), 32'd0);
    endtask

    logic [7:0] mon_prev_val;
    logic [1:0] mon_prev_cnt;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (!rstn) begin
            mon_prev_val = value;
            mon_prev_cnt = digit_cnt;
        end else if (entry_valid || key_err || value != mon_prev_val || digit_cnt != mon_prev_cnt) begin
            if (q.size() == 0) begin
                check("unexpected_output", {21'd0, entry_valid, key_err, value, digit_cnt}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("scoreboard", 32'({entry_valid, key_err, value, digit_cnt, entry_value}), 32'(mon_e));
            end
            mon_prev_val = value;
            mon_prev_cnt = digit_cnt;
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int code, r;
        rstn      = 1'b0;
        keys_down = '0;
        m_acc = 0; m_cnt = 0; m_ev = 0;
        wait_cyc(3);
        check_reset("reset");
        rstn = 1'b1;

        foreach (kmap[i]) if (i == 0) begin end
        press(1, 3, 3); press(2, 3, 3); press(3, 3, 3); press(15, 3, 3);
        check_state("seq123");

        press(2, 3, 3); press(5, 3, 3); press(6, 3, 3);
        check_state("overflow");
        press(5, 3, 3); press(15, 3, 3);
        check_state("max255");

        press(1, 3, 3); press(0, 3, 3); press(0, 3, 3); press(7, 3, 3);
        check_state("fourth");
        press(14, 3, 3); press(15, 3, 3);
        check_state("clear_empty_ent");

        // Bouncing '5' then a long hold: a single event only.
        model_key(5);
        for (int k = 0; k < 6; k++) begin
            keys_down[pos_of(5)] = (k % 2 == 0);
            wait_cyc(SCAN);
        end
        keys_down[pos_of(5)] = 1'b1;
        wait_cyc(20 * SCAN);
        keys_down[pos_of(5)] = 1'b0;
        wait_cyc(3 * SCAN);
        check_state("bounce");
        press(14, 3, 3);

        // Two keys together never fire; dropping one lets the other through.
        keys_down[pos_of(4)] = 1'b1;
        keys_down[pos_of(8)] = 1'b1;
        wait_cyc(4 * SCAN);
        check("multikey_no_event", 32'(value), 32'd0);
        model_key(4);
        keys_down[pos_of(8)] = 1'b0;
        wait_cyc(3 * SCAN + 4);
        check("multikey_single_left", 32'(value), 32'd4);
        keys_down[pos_of(4)] = 1'b0;
        wait_cyc(3 * SCAN);
        press(14, 3, 3);

        // Reset mid-entry while '9' is held.
        press(3, 3, 3); press(7, 3, 3);
        check("pre_reset_value", 32'(value), 32'd37);
        keys_down[pos_of(9)] = 1'b1;
        wait_cyc(8);
        rstn = 1'b0;
        wait_cyc(2);
        check_reset("midreset");
        check("midreset_pending", 32'(q.size()), 32'd0);
        m_acc = 0; m_cnt = 0; m_ev = 0;
        model_key(9);
        rstn = 1'b1;
        wait_cyc(20);
        check("redebounce_early", 32'(value), 32'd0);
        wait_cyc(20);
        check("redebounce_done", 32'(value), 32'd9);
        keys_down[pos_of(9)] = 1'b0;
        wait_cyc(3 * SCAN);
        check_state("after_reset");

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 19);
            if (r < 10)      code = r;
            else if (r < 13) code = 15;
            else if (r < 15) code = 14;
            else             code = 10 + (r - 15) % 4;
            press(code, $urandom_range(3, 4), $urandom_range(3, 4));
        end
        wait_cyc(5 * SCAN);
        check_state("random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
